// File: rtl/btn_debounce_onepulse_if.sv
// Button conditioner signal bundle: raw button level in, clean level and
// single-cycle event strobes out.
interface btn_debounce_onepulse_if;
    logic btn_in;
    logic btn_level;
    logic btn_pulse;
    logic btn_repeat;

    // Upstream side: drives the raw button, consumes the conditioned outputs.
    modport master (
        output btn_in,
        input  btn_level,
        input  btn_pulse,
        input  btn_repeat
    );

    // Conditioner side.
    modport slave (
        input  btn_in,
        output btn_level,
        output btn_pulse,
        output btn_repeat
    );
endinterface

// File: rtl/btn_debounce_onepulse.sv
// Push-button conditioner: 2-FF synchronizer, counter-based debounce FSM,
// one-pulse on accepted press and optional auto-repeat while held.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | released and stable, waiting for a synchronized high sample
// PRESS_CHK | counting consecutive high samples before accepting a press
// HELD      | press accepted, level high, hold timer drives auto-repeat
// REL_CHK   | counting consecutive low samples before accepting a release
module btn_debounce_onepulse #(
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    btn_debounce_onepulse_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             s1, btn_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             repeat_q, repeat_d;

    // Two-stage synchronizer for the asynchronous raw button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= bus.btn_in;
            btn_s <= s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            deb_q    <= '0;
            hold_q   <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            deb_q    <= deb_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            repeat_q <= repeat_d;
        end
    end

    // Next-state, counter and output decode; strobes default low so each
    // event lasts exactly one cycle.
    always_comb begin
        state_d  = state_q;
        deb_d    = deb_q;
        hold_d   = hold_q;
        level_d  = level_q;
        pulse_d  = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (btn_s) begin
                    state_d = PRESS_CHK;
                    deb_d   = CNT_ONE;
                end
            end

            PRESS_CHK: begin
                level_d = 1'b0;
                if (!btn_s) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HELD;
                    deb_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end

            HELD: begin
                level_d = 1'b1;
                if (!btn_s) begin
                    // Hold timer freezes so a release bounce only delays
                    // the repeat cadence instead of restarting it.
                    state_d = REL_CHK;
                    deb_d   = CNT_ONE;
                end else if (REPEAT_DELAY != 0) begin
                    if (hold_q == RPT_LAST) begin
                        repeat_d = 1'b1;
                        hold_d   = RPT_RELOAD;
                    end else begin
                        hold_d = hold_q + CNT_ONE;
                    end
                end
            end

            REL_CHK: begin
                level_d = 1'b1;
                if (btn_s) begin
                    state_d = HELD;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = IDLE;
                    deb_d   = '0;
                    level_d = 1'b0;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                deb_d   = '0;
                hold_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign bus.btn_level  = level_q;
    assign bus.btn_pulse  = pulse_q;
    assign bus.btn_repeat = repeat_q;

endmodule

// File: tb/tb_btn_debounce_onepulse.sv
module tb_btn_debounce_onepulse;

    logic clk;
    logic rst_n;

    btn_debounce_onepulse_if bif();

    btn_debounce_onepulse #(
        .STABLE_CYCLES (16),
        .REPEAT_DELAY  (64),
        .REPEAT_PERIOD (16),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        int   ncyc;
        int   exp_pulses;
        int   exp_repeats;
        logic exp_level;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int n_vec;
    int n_bad;
    int n_pulse;
    int n_rep;
    int overlap;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bif.btn_pulse)  n_pulse++;
            if (bif.btn_repeat) n_rep++;
            if (bif.btn_pulse && bif.btn_repeat) overlap++;
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        n_pulse = 0;
        n_rep   = 0;
        overlap = 0;

        // Clean press held 40 cycles, then release.
        vecs[0]  = '{1'b1,  17, 0, 0, 1'b0};
        vecs[1]  = '{1'b1,   1, 1, 0, 1'b1};
        vecs[2]  = '{1'b1,  22, 0, 0, 1'b1};
        vecs[3]  = '{1'b0,  17, 0, 0, 1'b1};
        vecs[4]  = '{1'b0,   1, 0, 0, 1'b0};
        vecs[5]  = '{1'b0,   5, 0, 0, 1'b0};
        // Press bounce, 5-cycle widths, then stable high.
        vecs[6]  = '{1'b1,   5, 0, 0, 1'b0};
        vecs[7]  = '{1'b0,   5, 0, 0, 1'b0};
        vecs[8]  = '{1'b1,   5, 0, 0, 1'b0};
        vecs[9]  = '{1'b0,   5, 0, 0, 1'b0};
        vecs[10] = '{1'b1,  17, 0, 0, 1'b0};
        vecs[11] = '{1'b1,   1, 1, 0, 1'b1};
        // Auto-repeat: acceptance+64, +80, then every 16 up to +192.
        vecs[12] = '{1'b1,  63, 0, 0, 1'b1};
        vecs[13] = '{1'b1,   1, 0, 1, 1'b1};
        vecs[14] = '{1'b1,  15, 0, 0, 1'b1};
        vecs[15] = '{1'b1,   1, 0, 1, 1'b1};
        vecs[16] = '{1'b1, 112, 0, 7, 1'b1};
        vecs[17] = '{1'b1,   8, 0, 0, 1'b1};
        // 5-cycle release bounce while held: 6 frozen edges, so the repeat
        // expected at acceptance+208 lands at +214.
        vecs[18] = '{1'b0,   5, 0, 0, 1'b1};
        vecs[19] = '{1'b1,   8, 0, 0, 1'b1};
        vecs[20] = '{1'b1,   1, 0, 1, 1'b1};

        // Reset held with button pressed: outputs stay low.
        rst_n = 1'b0;
        bif.btn_in = 1'b1;
        #1;
        check("rst_async_level", int'(bif.btn_level), 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("rst_c%0d_level", i), int'(bif.btn_level), 0);
            check($sformatf("rst_c%0d_strobes", i), int'(bif.btn_pulse) + int'(bif.btn_repeat), 0);
        end

        // Release with button already high: one debounced pulse at edge 17+1.
        rst_n   = 1'b1;
        n_pulse = 0;
        step(17);
        check("post_rst_early_pulse", n_pulse, 0);
        step(1);
        check("post_rst_pulse", int'(bif.btn_pulse), 1);
        check("post_rst_level", int'(bif.btn_level), 1);
        n_pulse = 0;
        step(30);
        check("post_rst_single_pulse", n_pulse, 0);
        bif.btn_in = 1'b0;
        step(20);
        check("post_rst_release_level", int'(bif.btn_level), 0);

        // Table-driven segments.
        for (int i = 0; i < NVEC; i++) begin
            bif.btn_in = vecs[i].btn;
            n_pulse = 0;
            n_rep   = 0;
            step(vecs[i].ncyc);
            check($sformatf("v%0d_pulses", i),  n_pulse, vecs[i].exp_pulses);
            check($sformatf("v%0d_repeats", i), n_rep,   vecs[i].exp_repeats);
            check($sformatf("v%0d_level", i),   int'(bif.btn_level), int'(vecs[i].exp_level));
        end

        // Reset mid-hold (btn_repeat is high right now): outputs drop before
        // the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_level", int'(bif.btn_level), 0);
        check("midrst_repeat", int'(bif.btn_repeat), 0);
        check("midrst_pulse", int'(bif.btn_pulse), 0);
        step(3);
        check("midrst_hold_level", int'(bif.btn_level), 0);
        rst_n   = 1'b1;
        n_pulse = 0;
        n_rep   = 0;
        step(17);
        check("midrst_early_pulse", n_pulse, 0);
        step(1);
        check("midrst_pulse_after", int'(bif.btn_pulse), 1);
        n_pulse = 0;
        step(30);
        check("midrst_single_pulse", n_pulse, 0);
        check("midrst_no_repeat", n_rep, 0);

        check("pulse_repeat_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce_onepulse.md
Name: btn_debounce_onepulse

Overview:
- Conditions a raw push-button or switch input into clean, single-cycle events for downstream registers and flip-flop stages.
- Stages: 2-FF synchronizer, then a counter-based debounce FSM, then a one-pulse generator with optional auto-repeat while the button is held.
- Sits directly upstream of the lab's register/shift stages and drives their data or enable inputs.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples required to accept a press or a release (must be >= 2).
- REPEAT_DELAY, 64, held cycles after acceptance before the first btn_repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 16, cycles between subsequent btn_repeat pulses (must be >= 1).
- CNT_W, 16, width of the internal counters; must hold max(STABLE_CYCLES, REPEAT_DELAY).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw, asynchronous, bouncing button level (1 = pressed).
- btn_level  output  1  debounced button level.
- btn_pulse  output  1  one-cycle pulse on each accepted press.
- btn_repeat  output  1  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset (rst_n=0, asynchronous): sync stages=0, state=IDLE, all counters=0, btn_level=0, btn_pulse=0, btn_repeat=0. Release of reset takes effect at the next posedge.
- Synchronizer: s1<=btn_in; btn_s<=s1. The FSM uses only btn_s.
- All outputs are registered. btn_pulse and btn_repeat are high for exactly one cycle per event.
- IDLE (level 0):
  - btn_s=1 -> PRESS_CHK, deb_cnt<=1.
- PRESS_CHK (level 0):
  - btn_s=0 -> IDLE, deb_cnt<=0.
  - btn_s=1 and deb_cnt==STABLE_CYCLES-1 -> HELD; btn_level<=1; btn_pulse<=1; hold_cnt<=0.
  - Otherwise deb_cnt++.
- HELD (level 1):
  - btn_s=0 -> REL_CHK, deb_cnt<=1; hold_cnt frozen.
  - Otherwise, if REPEAT_DELAY!=0: hold_cnt++.
  - When hold_cnt==REPEAT_DELAY-1: btn_repeat<=1 and hold_cnt<=REPEAT_DELAY-REPEAT_PERIOD. This yields the first repeat REPEAT_DELAY cycles after acceptance, then one every REPEAT_PERIOD.
- REL_CHK (level 1):
  - btn_s=1 -> HELD (bounce); hold_cnt resumes from its frozen value.
  - btn_s=0 and deb_cnt==STABLE_CYCLES-1 -> IDLE; btn_level<=0.
  - Otherwise deb_cnt++.
  - btn_repeat is never asserted in REL_CHK.
- Latency: btn_in stably 1 from before posedge E0 -> btn_level=1 and btn_pulse=1 after posedge E0+STABLE_CYCLES+1. Release is symmetric; no pulse on release.
- Boundaries:
  - Any glitch shorter than STABLE_CYCLES FSM samples produces no level change and no pulse.
  - btn_pulse and btn_repeat are never high in the same cycle; the first repeat is at least REPEAT_DELAY cycles after btn_pulse.
  - Counters never wrap; deb_cnt never exceeds STABLE_CYCLES-1.
  - Reset asserted mid-press drops all outputs immediately.
  - After reset release with btn_in already 1, a full debounce runs and exactly one btn_pulse is produced.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles with btn_in=1 -> all outputs 0 throughout; after release, btn_pulse is high for 1 cycle exactly STABLE_CYCLES+1 edges after the first capture (edge 17 with defaults).
- Clean press: btn_in 0->1 before edge E0, held 40 cycles, then 0 -> btn_pulse high only in the cycle after E0+17; btn_level high from E0+17 until 17 edges after the release; btn_repeat never asserted (40<64).
- Bounce: btn_in toggles 1,0,1,0 with 5-cycle widths, then stable 1 -> no pulse during the bounce; exactly one btn_pulse, 17 edges after the final rising edge is captured.
- Auto-repeat: hold btn_in=1 for 200 cycles after acceptance -> btn_repeat pulses at acceptance+64, +80, +96 … +192 (9 pulses); no pulse coincides with btn_pulse.
- Release bounce while held: in HELD, drop btn_in for 5 cycles, then restore -> btn_level stays 1, no new btn_pulse, and the repeat cadence is delayed by exactly the frozen cycles.
- Reset mid-operation: assert rst_n=0 in HELD while btn_level=1 -> btn_level=0 asynchronously (before the next clk edge); after release with btn_in=1, exactly one new btn_pulse is produced.
